// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU byte-serial sequencer: state encoding and
// EXEC counter width.
package alu_sequencer_pkg;

  // Sequencer states, 3-bit encoding shared with the surrounding CPU.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_AL  = 3'd1,
    S_LD_AH  = 3'd2,
    S_LD_BL  = 3'd3,
    S_LD_BH  = 3'd4,
    S_EXEC   = 3'd5,
    S_OUT_LO = 3'd6,
    S_OUT_HI = 3'd7
  } seq_state_t;

  // EXEC settle counter width; covers EXEC_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_seq_byte_reg.sv
// 8-bit load-enable register with asynchronous active-low reset.
// Holds ALU operands and captured results inside the sequencer.
module alu_seq_byte_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  // Load on enable, otherwise hold; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 8'h00;
    else if (en) q <= d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-serial front/back end around the 16-bit ALU. Collects an opcode and
// four operand bytes, holds them on the ALU ports, waits EXEC_CYCLES for
// the ALU to settle, captures the result and flags, then returns the
// result as two bytes (low, high) on a valid/ready bus.
//
// Optional build macro ALU_SEQ_LOCAL_ZEROF_EN: when defined the zero flag
// is derived locally from the 16-bit ALU result and alu_zerof is ignored;
// otherwise the ALU's own zero flag is captured.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_LD_AL  | waiting for operand A low byte
// S_LD_AH  | waiting for operand A high byte
// S_LD_BL  | waiting for operand B low byte
// S_LD_BH  | waiting for operand B high byte
// S_EXEC   | ALU settling, capture on the last settle cycle
// S_OUT_LO | presenting result low byte
// S_OUT_HI | presenting result high byte with out_last
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int OP_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                cmd_valid,
  input  logic [OP_WIDTH-1:0] cmd_op,
  output logic                cmd_ready,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                out_zerof,
  output logic                out_overf,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [7:0]          alu_a_low,
  output logic [7:0]          alu_a_high,
  output logic [7:0]          alu_b_low,
  output logic [7:0]          alu_b_high,
  input  logic [7:0]          alu_res_low,
  input  logic [7:0]          alu_res_high,
  input  logic                alu_zerof,
  input  logic                alu_overf
);

  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

  seq_state_t          state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [OP_WIDTH-1:0] op_q;
  logic [7:0]          res_low, res_high;
  logic                zf_q, of_q, zero_cap;
  logic                op_en, al_en, ah_en, bl_en, bh_en, cap_en;

`ifdef ALU_SEQ_LOCAL_ZEROF_EN
  logic unused_alu_zerof;
  assign zero_cap         = (alu_res_high == 8'h00) && (alu_res_low == 8'h00);
  assign unused_alu_zerof = alu_zerof;
`else
  assign zero_cap = alu_zerof;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state, handshake outputs and register load enables; flush overrides all.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    op_en     = 1'b0;
    al_en     = 1'b0;
    ah_en     = 1'b0;
    bl_en     = 1'b0;
    bh_en     = 1'b0;
    cap_en    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_en    = 1'b1;
          state_nx = S_LD_AL;
        end
      end
      S_LD_AL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          al_en    = 1'b1;
          state_nx = S_LD_AH;
        end
      end
      S_LD_AH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ah_en    = 1'b1;
          state_nx = S_LD_BL;
        end
      end
      S_LD_BL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bl_en    = 1'b1;
          state_nx = S_LD_BH;
        end
      end
      S_LD_BH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bh_en    = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt == EXEC_LAST) begin
          cap_en   = 1'b1;
          state_nx = S_OUT_LO;
        end
      end
      S_OUT_LO: begin
        out_valid = 1'b1;
        out_data  = res_low;
        if (out_ready) state_nx = S_OUT_HI;
      end
      S_OUT_HI: begin
        out_valid = 1'b1;
        out_data  = res_high;
        out_last  = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // A flushed beat or command must not touch the data registers.
    if (flush) begin
      state_nx = S_IDLE;
      op_en    = 1'b0;
      al_en    = 1'b0;
      ah_en    = 1'b0;
      bl_en    = 1'b0;
      bh_en    = 1'b0;
      cap_en   = 1'b0;
    end
  end

  // Settle counter: zero on EXEC entry, counts while staying in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    cnt <= '0;
    else if (state == S_EXEC && state_nx == S_EXEC) cnt <= cnt + 1'b1;
    else                                           cnt <= '0;
  end

  // Opcode register, held on the ALU until the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     op_q <= '0;
    else if (op_en) op_q <= cmd_op;
  end

  // Captured flags, presented with the result bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cap_en) begin
      zf_q <= zero_cap;
      of_q <= alu_overf;
    end
  end

  alu_seq_byte_reg u_a_low   (.clk(clk), .rst_n(rst_n), .en(al_en),  .d(in_data),      .q(alu_a_low));
  alu_seq_byte_reg u_a_high  (.clk(clk), .rst_n(rst_n), .en(ah_en),  .d(in_data),      .q(alu_a_high));
  alu_seq_byte_reg u_b_low   (.clk(clk), .rst_n(rst_n), .en(bl_en),  .d(in_data),      .q(alu_b_low));
  alu_seq_byte_reg u_b_high  (.clk(clk), .rst_n(rst_n), .en(bh_en),  .d(in_data),      .q(alu_b_high));
  alu_seq_byte_reg u_res_low (.clk(clk), .rst_n(rst_n), .en(cap_en), .d(alu_res_low),  .q(res_low));
  alu_seq_byte_reg u_res_high(.clk(clk), .rst_n(rst_n), .en(cap_en), .d(alu_res_high), .q(res_high));

  assign alu_op    = op_q;
  assign out_zerof = zf_q;
  assign out_overf = of_q;

endmodule
